sram_port_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `sram_4kb` (1024 × 32-bit words). Port 0 is the CPU load/store path and port 1 is the instruction-fetch/host-loader path. Each cycle the block grants at most one request, drives the SRAM, and returns read data to the owning port one cycle later. It supports round-robin fairness and a bounded bus lock for read-modify-write sequences.

---
 rtl/sram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Two-port arbiter and sequencer in front of a single-port 1024 x 32 SRAM.
// Port 0 is the CPU load/store path and port 1 is the instruction-fetch /
// host-loader path. At most one request is granted per cycle. The granted
// port drives the SRAM combinationally, and read data returns to the owning
// port one cycle later. Arbitration in IDLE is round-robin. A port may lock
// the bus for read-modify-write sequences, but the lock is forcibly released
// after LOCK_MAX cycles.
//
// Ports
//   clk, reset               clock; synchronous active-high reset
//   mX_req/we/lock           request, write enable, keep ownership after access
//   mX_addr/wdata            word address and write data
//   mX_gnt                   combinational grant (request accepted this cycle)
//   mX_rvalid                registered read-data valid (cycle after grant)
//   mX_rdata                 read data (both ports carry sram_data_out)
//   sram_we/addr/data_in     SRAM drive, zero when nothing is granted
//   sram_data_out            SRAM read data, one cycle after the address
//   busy                     bus owned or a read response pending
//   lock_err                 sticky flag: a lock hit the LOCK_MAX limit
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  // port 0
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  // port 1
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  // SRAM side
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  // status
  output logic              busy,
  output logic              lock_err
);

  // The counter only ever holds 0 .. LOCK_MAX-1; the limit is detected one
  // step before it would wrap.
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;         // last port granted
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               pend_q, pend_d;         // read response due next cycle
  logic               pend_id_q, pend_id_d;   // port owning that response
  logic               lock_err_q, lock_err_d;

  logic               gnt0, gnt1, any_gnt;
  logic               gnt_we, gnt_lock;

  // ---------------------------------------------------------------------------
  // Grant selection. Nothing is granted while reset is high so that no SRAM
  // write slips through in the reset cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            // tie: the port that did not win last time goes first
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign gnt_we   = gnt0 ? m0_we   : (gnt1 & m1_we);
  assign gnt_lock = gnt0 ? m0_lock : (gnt1 & m1_lock);

  // SRAM drive follows the winner; an idle bus presents all zeros.
  always_comb begin
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_data_in = '0;
    if (gnt0) begin
      sram_we      = m0_we;
      sram_addr    = m0_addr;
      sram_data_in = m0_wdata;
    end else if (gnt1) begin
      sram_we      = m1_we;
      sram_addr    = m1_addr;
      sram_data_in = m1_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: ownership, round-robin pointer, lock counter.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    lock_err_d = lock_err_q;
    pend_d     = any_gnt && !gnt_we;
    pend_id_d  = gnt1;

    if (any_gnt) last_d = gnt1;

    unique case (state_q)
      IDLE: begin
        if (any_gnt && gnt_lock) begin
          state_d    = gnt1 ? OWN1 : OWN0;
          lock_cnt_d = '0;
        end
      end
      OWN0, OWN1: begin
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!any_gnt || !gnt_lock) begin
          // owner dropped its request or issued its final unlocked access
          state_d = IDLE;
        end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          // limit reached: this cycle's grant stands, then ownership is
          // revoked and the other port wins the next tie
          state_d    = IDLE;
          lock_err_d = 1'b1;
          last_d     = (state_q == OWN1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      pend_q     <= 1'b0;
      pend_id_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      pend_q     <= pend_d;
      pend_id_q  <= pend_id_d;
      lock_err_q <= lock_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. A response still registered when reset arrives is suppressed in
  // the reset cycle itself, so the dropped read never reaches its port.
  // ---------------------------------------------------------------------------
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = pend_q && !pend_id_q && !reset;
  assign m1_rvalid = pend_q &&  pend_id_q && !reset;
  assign m0_rdata  = sram_data_out;
  assign m1_rdata  = sram_data_out;
  assign busy      = (state_q != IDLE) || pend_q;
  assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter with a behavioural SRAM. The stimulus
// task checks grants and SRAM drive each cycle and pushes the expected read
// response (port, data, cycle) into a queue; an independent monitor pops and
// compares whenever an rvalid appears.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_data_in, sram_data_out;
  logic              busy, lock_err;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_lock      (m0_lock),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_gnt       (m0_gnt),
    .m0_rvalid    (m0_rvalid),
    .m0_rdata     (m0_rdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_lock      (m1_lock),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_gnt       (m1_gnt),
    .m1_rvalid    (m1_rvalid),
    .m1_rdata     (m1_rdata),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_data_in (sram_data_in),
    .sram_data_out(sram_data_out),
    .busy         (busy),
    .lock_err     (lock_err)
  );

  always #5 clk = ~clk;

  // behavioural single-port SRAM, one-cycle read latency
  logic [DATA_W-1:0] mem     [1024];
  logic [DATA_W-1:0] ref_mem [1024];

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_data_in;
    sram_data_out <= mem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    int                due;
  } resp_t;

  resp_t exp_q[$];

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (m0_rvalid === 1'b1 && m1_rvalid === 1'b1)
        check("rvalid_both_ports", 32'd1, 32'd0);
      if (m0_rvalid === 1'b1 || m1_rvalid === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          check("rvalid_port", {31'b0, m1_rvalid}, {31'b0, e.port});
          check("rdata", m1_rvalid ? m1_rdata : m0_rdata, e.data);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("rvalid_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set0(input logic req, input logic we, input logic lock,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = data;
  endtask

  task automatic set1(input logic req, input logic we, input logic lock,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = data;
  endtask

  // One cycle: inputs are already set; check grants and SRAM drive at the
  // falling edge, record the expected effect, then advance past the rising edge.
  task automatic step(input logic eg0, input logic eg1);
    resp_t e;
    @(negedge clk);
    check("m0_gnt", {31'b0, m0_gnt}, {31'b0, eg0});
    check("m1_gnt", {31'b0, m1_gnt}, {31'b0, eg1});
    if (eg0 || eg1) begin
      check("sram_we",      {31'b0, sram_we}, {31'b0, eg0 ? m0_we : m1_we});
      check("sram_addr",    {22'b0, sram_addr}, {22'b0, eg0 ? m0_addr : m1_addr});
      check("sram_data_in", sram_data_in, eg0 ? m0_wdata : m1_wdata);
    end else begin
      check("sram_idle", {21'b0, sram_we, sram_addr}, 32'd0);
    end
    if (reset) begin
      check("rvalid_in_reset", {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
      exp_q.delete();
    end else if (eg0 || eg1) begin
      logic              we;
      logic [ADDR_W-1:0] a;
      we = eg0 ? m0_we : m1_we;
      a  = eg0 ? m0_addr : m1_addr;
      if (we) begin
        ref_mem[a] = eg0 ? m0_wdata : m1_wdata;
      end else begin
        e.port = eg1;
        e.data = ref_mem[a];
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    step(0, 0);
    step(0, 0);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    quiet();
    reset = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // reset state
    check("busy_after_reset",     {31'b0, busy}, 32'd0);
    check("lock_err_after_reset", {31'b0, lock_err}, 32'd0);
    step(0, 0);

    // single port: write then read the same word in consecutive cycles
    set0(1, 1, 0, 10'h005, 32'hDEAD_BEEF); step(1, 0);
    set0(1, 0, 0, 10'h005, 32'h0);         step(1, 0);
    quiet();                               step(0, 0);
    step(0, 0);

    // contention from reset: grants alternate 0,1,0,1,0,1
    do_reset();
    set0(1, 0, 0, 10'h010, 32'h0);
    set1(1, 0, 0, 10'h020, 32'h0);
    for (int i = 0; i < 6; i++) step(i % 2 == 0, i % 2 == 1);
    quiet(); step(0, 0);

    // lock: port 0 goes first alone so port 1 wins the following tie
    set0(1, 0, 0, 10'h030, 32'h0);          step(1, 0);
    set0(1, 0, 0, 10'h031, 32'h0);
    set1(1, 1, 1, 10'h040, 32'hAAAA_0001);  step(0, 1);
    check("busy_owned", {31'b0, busy}, 32'd1);
    set1(1, 0, 1, 10'h040, 32'h0);          step(0, 1);
    set1(1, 1, 1, 10'h041, 32'hBBBB_0002);  step(0, 1);
    set1(1, 0, 0, 10'h041, 32'h0);          step(0, 1);
    set1(0, 0, 0, 10'h000, 32'h0);          step(1, 0);
    quiet(); step(0, 0);

    // lock timeout: one IDLE grant plus 16 cycles in OWN1
    set1(1, 0, 1, 10'h050, 32'h0);
    for (int i = 0; i < 16; i++) step(0, 1);
    check("lock_err_before_limit", {31'b0, lock_err}, 32'd0);
    step(0, 1);
    check("lock_err_set", {31'b0, lock_err}, 32'd1);
    set0(1, 0, 0, 10'h051, 32'h0);          step(1, 0);
    set0(0, 0, 0, 10'h000, 32'h0);          step(0, 1);
    step(0, 1);
    set1(0, 0, 0, 10'h000, 32'h0);          step(0, 0);
    check("lock_err_sticky", {31'b0, lock_err}, 32'd1);

    // lock release by dropping the request
    set0(1, 0, 1, 10'h060, 32'h0);          step(1, 0);
    set0(1, 1, 1, 10'h060, 32'hCCCC_0003);
    set1(1, 0, 0, 10'h061, 32'h0);          step(1, 0);
    set0(0, 0, 0, 10'h000, 32'h0);          step(0, 0);
    set0(1, 0, 0, 10'h060, 32'h0);          step(0, 1);
    set1(0, 0, 0, 10'h000, 32'h0);          step(1, 0);
    quiet(); step(0, 0);

    // reset mid-operation, in OWN0 with a read outstanding
    set0(1, 0, 1, 10'h070, 32'h0);          step(1, 0);
    set0(1, 0, 1, 10'h071, 32'h0);
    set1(1, 0, 0, 10'h072, 32'h0);          step(1, 0);
    reset = 1'b1;                           step(0, 0);
    reset = 1'b0;
    check("busy_post_reset",     {31'b0, busy}, 32'd0);
    check("lock_err_post_reset", {31'b0, lock_err}, 32'd0);
    set0(1, 0, 0, 10'h071, 32'h0);          step(1, 0);
    set0(0, 0, 0, 10'h000, 32'h0);          step(0, 1);
    quiet(); step(0, 0);
    step(0, 0);

    check("responses_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
